// File: rtl/audio_capture_channel.sv
`default_nettype none
// ============================================================================
// Module   : audio_capture_channel
// Purpose  : Sample-clock driven audio capture with gain, stereo/mono word
//            packing, a small word FIFO and a DMA write-back master.
// Revision : 1.0
// ============================================================================
module audio_capture_channel #(
    parameter int SAMPLE_FIFO_DEPTH = 4
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_dma_setup_request,
    input  logic        i_dma_setup_mono_or_stereo,
    input  logic [31:0] i_dma_setup_address,
    input  logic [23:0] i_dma_setup_count,
    output logic        o_dma_request,
    output logic [31:0] o_dma_address,
    output logic [31:0] o_dma_wdata,
    input  logic        i_dma_ready,
    output logic        o_busy,
    output logic        o_overflow,
    input  logic [3:0]  i_volume,
    input  logic        i_input_sample_clock,
    input  logic [15:0] i_input_sample_left,
    input  logic [15:0] i_input_sample_right
);

    localparam int c_PTR_W = $clog2(SAMPLE_FIFO_DEPTH);

    logic               r_last_sample_clock;
    logic               r_pend_valid;
    logic               r_pend_stereo;
    logic [31:0]        r_pend_addr;
    logic [23:0]        r_pend_count;
    logic               r_stereo;
    logic [23:0]        r_cap_count;
    logic [23:0]        r_word_count;
    logic [31:0]        r_waddr;
    logic               r_stage_valid;
    logic               r_stage_last;
    logic [15:0]        r_stage_left;
    logic [15:0]        r_stage_right;
    logic               r_pack_full;
    logic [15:0]        r_pack;
    logic [31:0]        r_fifo_data [SAMPLE_FIFO_DEPTH];
    logic [31:0]        r_fifo_addr [SAMPLE_FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic               r_dma_request;
    logic [31:0]        r_dma_address;
    logic [31:0]        r_dma_wdata;
    logic               r_overflow;

    logic               w_apply;
    logic               w_edge;
    logic signed [19:0] w_prod_left;
    logic signed [19:0] w_prod_right;
    logic [24:0]        w_mono_words;
    logic               w_unused_bits;
    logic [c_PTR_W-1:0] w_wr_ptr_inc;
    logic               w_empty;
    logic               w_full;
    logic               w_push_req;
    logic [31:0]        w_push_word;
    logic               w_pack_load;
    logic               w_pack_clear;
    logic               w_push_ok;
    logic               w_drop;
    logic               w_pop;
    logic               w_raise;
    logic [31:0]        w_head_addr;
    logic [31:0]        w_head_data;
    logic [1:0]         w_wc_dec;
    logic [23:0]        w_word_count_next;

    // A pending setup may only take effect while no bus write is outstanding.
    assign w_apply = r_pend_valid & ~r_dma_request;
    assign w_edge  = (i_input_sample_clock != r_last_sample_clock) &
                     (r_cap_count != 24'd0) & ~w_apply;

    assign w_prod_left  = $signed(i_input_sample_left)  * $signed({1'b0, i_volume});
    assign w_prod_right = $signed(i_input_sample_right) * $signed({1'b0, i_volume});
    assign w_mono_words = {1'b0, r_pend_count} + 25'd1;
    assign w_unused_bits = ^{w_prod_left[3:0], w_prod_right[3:0], w_mono_words[0]};

    assign w_wr_ptr_inc = r_wr_ptr + c_PTR_W'(1);
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (w_wr_ptr_inc == r_rd_ptr);

    always_comb begin
        w_push_req   = 1'b0;
        w_push_word  = 32'd0;
        w_pack_load  = 1'b0;
        w_pack_clear = 1'b0;
        if (r_stage_valid) begin
            if (r_stereo) begin
                w_push_req  = 1'b1;
                w_push_word = {r_stage_left, r_stage_right};
            end else if (r_pack_full) begin
                w_push_req   = 1'b1;
                w_push_word  = {r_stage_left, r_pack};
                w_pack_clear = 1'b1;
            end else if (r_stage_last) begin
                w_push_req  = 1'b1;
                w_push_word = {16'h0000, r_stage_left};
            end else begin
                w_pack_load = 1'b1;
            end
        end
    end

    assign w_push_ok = w_push_req & ~w_full;
    assign w_drop    = w_push_req & w_full;
    assign w_pop     = r_dma_request & i_dma_ready;

    // Each entry carries its own address so drops leave gaps without shifting
    // words that are already buffered. An empty FIFO forwards the word being pushed.
    assign w_head_addr = w_empty ? r_waddr     : r_fifo_addr[r_rd_ptr];
    assign w_head_data = w_empty ? w_push_word : r_fifo_data[r_rd_ptr];
    assign w_raise     = ~r_dma_request & ~w_apply & (r_word_count != 24'd0) &
                         (~w_empty | w_push_ok);

    assign w_wc_dec          = {1'b0, w_pop} + {1'b0, w_drop};
    assign w_word_count_next = (r_word_count > {22'd0, w_wc_dec}) ?
                               (r_word_count - {22'd0, w_wc_dec}) : 24'd0;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last_sample_clock <= 1'b0;
            r_pend_valid        <= 1'b0;
            r_pend_stereo       <= 1'b0;
            r_pend_addr         <= 32'd0;
            r_pend_count        <= 24'd0;
            r_stereo            <= 1'b0;
            r_cap_count         <= 24'd0;
            r_word_count        <= 24'd0;
            r_waddr             <= 32'd0;
            r_stage_valid       <= 1'b0;
            r_stage_last        <= 1'b0;
            r_stage_left        <= 16'd0;
            r_stage_right       <= 16'd0;
            r_pack_full         <= 1'b0;
            r_pack              <= 16'd0;
            r_wr_ptr            <= '0;
            r_rd_ptr            <= '0;
            r_dma_request       <= 1'b0;
            r_dma_address       <= 32'd0;
            r_dma_wdata         <= 32'd0;
            r_overflow          <= 1'b0;
        end else begin
            r_last_sample_clock <= i_input_sample_clock;

            if (i_dma_setup_request) begin
                r_pend_valid  <= 1'b1;
                r_pend_stereo <= i_dma_setup_mono_or_stereo;
                r_pend_addr   <= i_dma_setup_address;
                r_pend_count  <= i_dma_setup_count;
            end else if (w_apply) begin
                r_pend_valid <= 1'b0;
            end

            if (w_apply) begin
                r_stereo      <= r_pend_stereo;
                r_waddr       <= r_pend_addr;
                r_cap_count   <= r_pend_count;
                r_word_count  <= r_pend_stereo ? r_pend_count : w_mono_words[24:1];
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_stage_valid <= 1'b0;
                r_pack_full   <= 1'b0;
                r_overflow    <= 1'b0;
            end else begin
                r_stage_valid <= w_edge;
                if (w_edge) begin
                    r_stage_left  <= w_prod_left[19:4];
                    r_stage_right <= w_prod_right[19:4];
                    r_stage_last  <= (r_cap_count == 24'd1);
                    r_cap_count   <= r_cap_count - 24'd1;
                end

                if (w_pack_load) begin
                    r_pack      <= r_stage_left;
                    r_pack_full <= 1'b1;
                end else if (w_pack_clear) begin
                    r_pack_full <= 1'b0;
                end

                if (w_push_ok) begin
                    r_fifo_data[r_wr_ptr] <= w_push_word;
                    r_fifo_addr[r_wr_ptr] <= r_waddr;
                    r_wr_ptr              <= w_wr_ptr_inc;
                end
                if (w_push_req) begin
                    r_waddr <= r_waddr + 32'd4;
                end
                if (w_drop) begin
                    r_overflow <= 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                r_word_count <= w_word_count_next;

                if (w_pop) begin
                    r_dma_request <= 1'b0;
                end else if (w_raise) begin
                    r_dma_request <= 1'b1;
                    r_dma_address <= w_head_addr;
                    r_dma_wdata   <= w_head_data;
                end
            end
        end
    end

    assign o_dma_request = r_dma_request;
    assign o_dma_address = r_dma_address;
    assign o_dma_wdata   = r_dma_wdata;
    assign o_overflow    = r_overflow;
    // A pending zero-count setup leaves the channel idle, so it does not count as busy.
    assign o_busy = (r_cap_count != 24'd0) | (r_word_count != 24'd0) | r_dma_request |
                    (r_pend_valid & (r_pend_count != 24'd0));

endmodule
`default_nettype wire

// File: tb/tb_audio_capture_channel.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_capture_channel
// Purpose  : Directed self-checking bench for audio_capture_channel.
// Revision : 1.0
// ============================================================================
module tb_audio_capture_channel;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        setup_req = 1'b0;
    logic        setup_stereo = 1'b0;
    logic [31:0] setup_addr = 32'd0;
    logic [23:0] setup_count = 24'd0;
    logic        dma_request;
    logic [31:0] dma_address;
    logic [31:0] dma_wdata;
    logic        dma_ready = 1'b0;
    logic        busy;
    logic        overflow;
    logic [3:0]  volume = 4'd15;
    logic        sclk = 1'b0;
    logic [15:0] left = 16'd0;
    logic [15:0] right = 16'd0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    logic [15:0] ovf_l [5] = '{16'h0010, 16'h0100, 16'h1000, 16'h4000, 16'h0001};
    logic [15:0] ovf_r [5] = '{16'h0020, 16'h0200, 16'h2000, 16'h4000, 16'h0001};
    logic [31:0] ovf_w [3] = '{32'h000F001E, 32'h00F001E0, 32'h0F001E00};

    audio_capture_channel #(.SAMPLE_FIFO_DEPTH(4)) dut (
        .i_clock                    (clock),
        .i_reset                    (reset),
        .i_dma_setup_request        (setup_req),
        .i_dma_setup_mono_or_stereo (setup_stereo),
        .i_dma_setup_address        (setup_addr),
        .i_dma_setup_count          (setup_count),
        .o_dma_request              (dma_request),
        .o_dma_address              (dma_address),
        .o_dma_wdata                (dma_wdata),
        .i_dma_ready                (dma_ready),
        .o_busy                     (busy),
        .o_overflow                 (overflow),
        .i_volume                   (volume),
        .i_input_sample_clock       (sclk),
        .i_input_sample_left        (left),
        .i_input_sample_right       (right)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset && dma_request && dma_ready) begin
            log_addr.push_back(dma_address);
            log_data.push_back(dma_wdata);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] la(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] ld(input int i);
        return (i < log_data.size()) ? log_data[i] : 32'hxxxxxxxx;
    endfunction

    task automatic setup(input logic st, input logic [31:0] a, input logic [23:0] c);
        setup_req    = 1'b1;
        setup_stereo = st;
        setup_addr   = a;
        setup_count  = c;
        step(1);
        setup_req = 1'b0;
    endtask

    task automatic sample(input logic [15:0] l, input logic [15:0] r);
        left  = l;
        right = r;
        sclk  = ~sclk;
        step(1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 200) begin
            step(1);
            k++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        // Reset state
        step(2);
        check("rst_req",  {31'd0, dma_request}, 32'd0);
        check("rst_addr", dma_address, 32'd0);
        check("rst_data", dma_wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovf",  {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        step(1);

        // Stereo capture, full gain, ready tied high
        dma_ready = 1'b1;
        volume    = 4'd15;
        setup(1'b1, 32'h1000_0000, 24'd3);
        step(1);
        clear_log();
        sample(16'h1000, 16'h2000);
        check("st_lat_pre", {31'd0, dma_request}, 32'd0);
        step(1);
        check("st_lat_req",  {31'd0, dma_request}, 32'd1);
        check("st_lat_addr", dma_address, 32'h1000_0000);
        check("st_lat_data", dma_wdata, 32'h0F001E00);
        step(3);
        sample(16'h7FF0, 16'h8000);
        step(4);
        sample(16'hFFF0, 16'h0010);
        wait_idle("st_idle");
        check("st_nwr", 32'(log_addr.size()), 32'd3);
        check("st_a0", la(0), 32'h1000_0000);
        check("st_d0", ld(0), 32'h0F001E00);
        check("st_a1", la(1), 32'h1000_0004);
        check("st_d1", ld(1), 32'h77F18800);
        check("st_a2", la(2), 32'h1000_0008);
        check("st_d2", ld(2), 32'hFFF1000F);

        // Mono capture, full gain: two samples packed, odd one padded
        clear_log();
        setup(1'b0, 32'h2000_0100, 24'd3);
        step(1);
        sample(16'h0100, 16'h1234);
        step(2);
        sample(16'h0200, 16'h1234);
        step(2);
        sample(16'h0300, 16'h1234);
        wait_idle("mono_idle");
        check("mono_nwr", 32'(log_addr.size()), 32'd2);
        check("mono_a0", la(0), 32'h2000_0100);
        check("mono_d0", ld(0), 32'h01E000F0);
        check("mono_a1", la(1), 32'h2000_0104);
        check("mono_d1", ld(1), 32'h000002D0);

        // Mono capture, zero gain
        clear_log();
        volume = 4'd0;
        setup(1'b0, 32'h2000_0200, 24'd3);
        step(1);
        sample(16'h7FFF, 16'h1234);
        step(2);
        sample(16'h8000, 16'h1234);
        step(2);
        sample(16'h0300, 16'h1234);
        wait_idle("mono0_idle");
        check("mono0_nwr", 32'(log_addr.size()), 32'd2);
        check("mono0_d0", ld(0), 32'h0000_0000);
        check("mono0_a1", la(1), 32'h2000_0204);
        check("mono0_d1", ld(1), 32'h0000_0000);
        volume = 4'd15;

        // Overflow: ready held low, five stereo edges into a depth-4 FIFO
        clear_log();
        dma_ready = 1'b0;
        setup(1'b1, 32'h3000_0000, 24'd5);
        step(1);
        for (int i = 0; i < 3; i++) begin
            sample(ovf_l[i], ovf_r[i]);
            step(1);
        end
        step(1);
        check("ovf_pre",  {31'd0, overflow}, 32'd0);
        check("ovf_req",  {31'd0, dma_request}, 32'd1);
        check("ovf_addr", dma_address, 32'h3000_0000);
        check("ovf_data", dma_wdata, ovf_w[0]);
        sample(ovf_l[3], ovf_r[3]);
        step(2);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        sample(ovf_l[4], ovf_r[4]);
        step(2);
        check("ovf_busy", {31'd0, busy}, 32'd1);
        dma_ready = 1'b1;
        wait_idle("ovf_idle");
        check("ovf_nwr", 32'(log_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("ovf_a%0d", i), la(i), 32'h3000_0000 + 32'(4 * i));
            check($sformatf("ovf_d%0d", i), ld(i), ovf_w[i]);
        end
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // New setup while a request is stalled
        clear_log();
        dma_ready = 1'b0;
        setup(1'b1, 32'h4000_0000, 24'd5);
        step(1);
        for (int i = 0; i < 4; i++) begin
            sample(ovf_l[i], ovf_r[i]);
            step(1);
        end
        step(1);
        check("stall_ovf", {31'd0, overflow}, 32'd1);
        setup(1'b1, 32'h5000_0000, 24'd1);
        step(3);
        check("stall_req",  {31'd0, dma_request}, 32'd1);
        check("stall_addr", dma_address, 32'h4000_0000);
        dma_ready = 1'b1;
        step(1);
        dma_ready = 1'b0;
        check("stall_drop", {31'd0, dma_request}, 32'd0);
        check("stall_wr_a", la(0), 32'h4000_0000);
        step(1);
        check("stall_ovf_clr", {31'd0, overflow}, 32'd0);
        step(2);
        check("stall_flush", {31'd0, dma_request}, 32'd0);
        clear_log();
        dma_ready = 1'b1;
        sample(16'h0010, 16'h0020);
        wait_idle("stall_idle");
        check("stall_nwr", 32'(log_addr.size()), 32'd1);
        check("stall_a0", la(0), 32'h5000_0000);
        check("stall_d0", ld(0), 32'h000F001E);

        // Zero-count setup and edges while idle
        clear_log();
        setup(1'b1, 32'h6000_0000, 24'd0);
        check("zero_busy0", {31'd0, busy}, 32'd0);
        step(1);
        sample(16'h1000, 16'h1000);
        step(1);
        sample(16'h2000, 16'h2000);
        step(3);
        check("zero_busy1", {31'd0, busy}, 32'd0);
        check("zero_req",   {31'd0, dma_request}, 32'd0);
        check("zero_nwr",   32'(log_addr.size()), 32'd0);

        // Reset mid-capture, then a normal capture
        dma_ready = 1'b0;
        setup(1'b1, 32'h7000_0000, 24'd4);
        step(1);
        sample(16'h0100, 16'h0200);
        step(1);
        sample(16'h0100, 16'h0200);
        step(3);
        check("mid_req", {31'd0, dma_request}, 32'd1);
        reset = 1'b1;
        step(1);
        check("mid_rst_req",  {31'd0, dma_request}, 32'd0);
        check("mid_rst_addr", dma_address, 32'd0);
        check("mid_rst_data", dma_wdata, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ovf",  {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        step(1);
        clear_log();
        dma_ready = 1'b1;
        setup(1'b1, 32'h8000_0000, 24'd1);
        step(1);
        sample(16'h0010, 16'h0020);
        wait_idle("post_idle");
        check("post_nwr", 32'(log_addr.size()), 32'd1);
        check("post_a0", la(0), 32'h8000_0000);
        check("post_d0", ld(0), 32'h000F001E);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
